// File: rtl/cpu_multicycle.sv
// Multicycle MIPS-subset core: one shared memory port for fetch and data, one FSM stepping each instruction.
// state     | meaning
// FETCH     | request instruction at PC, latch IR and PC+4 on ack
// DECODE    | read rs/rt into A/B, trap illegal encodings to HALT
// EXECUTE   | ALU op into ALUOut, resolve branches/jumps/syscall
// MEM       | load/store at ALUOut, wait for ack
// WRITEBACK | write destination register
// HALT      | stopped until reset
module cpu_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       pc_out,
  output logic              retired,
  output logic              halted
);

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT} state_t;

  state_t      state;
  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] rf [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, waddr;
  logic [31:0] sext, zext, br_off, jump_tgt, alu_res, wdata, byte_addr;
  logic        is_r;
  logic        op_add, op_sub, op_slt, op_jr, op_sys;
  logic        op_addi, op_xori, op_lw, op_sw, op_bne, op_j, op_jal, legal;

  assign opcode   = ir[31:26];
  assign funct    = ir[5:0];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign sext     = {{16{ir[15]}}, ir[15:0]};
  assign zext     = {16'h0000, ir[15:0]};
  assign br_off   = {sext[29:0], 2'b00};
  assign jump_tgt = {pc[31:28], ir[25:0], 2'b00};

  assign is_r    = (opcode == 6'h00);
  assign op_add  = is_r && (funct == 6'h20);
  assign op_sub  = is_r && (funct == 6'h22);
  assign op_slt  = is_r && (funct == 6'h2A);
  assign op_jr   = is_r && (funct == 6'h08);
  assign op_sys  = is_r && (funct == 6'h0C);
  assign op_addi = (opcode == 6'h08);
  assign op_xori = (opcode == 6'h0E);
  assign op_lw   = (opcode == 6'h23);
  assign op_sw   = (opcode == 6'h2B);
  assign op_bne  = (opcode == 6'h05);
  assign op_j    = (opcode == 6'h02);
  assign op_jal  = (opcode == 6'h03);
  assign legal   = op_add | op_sub | op_slt | op_jr | op_sys | op_addi | op_xori
                 | op_lw | op_sw | op_bne | op_j | op_jal;

  // Default result is the already-incremented PC, which is the JAL link value.
  always_comb begin
    alu_res = pc;
    if (op_add)                         alu_res = a + b;
    else if (op_sub)                    alu_res = a - b;
    else if (op_slt)                    alu_res = {31'd0, $signed(a) < $signed(b)};
    else if (op_addi || op_lw || op_sw) alu_res = a + sext;
    else if (op_xori)                   alu_res = a ^ zext;
  end

  assign waddr = is_r ? rd : (op_jal ? 5'd31 : rt);
  assign wdata = op_lw ? mdr : alu_out;

  // Bus outputs are decoded from registered state; reset gating keeps the bus idle during reset.
  assign byte_addr = (state == MEM) ? alu_out : pc;
  assign mem_req   = !reset && (state == FETCH || state == MEM);
  assign mem_we    = mem_req && (state == MEM) && op_sw;
  assign mem_addr  = byte_addr[ADDR_W-1:0];
  assign mem_wdata = b;
  assign pc_out    = pc;
  assign halted    = !reset && (state == HALT);
  assign retired   = !reset && ((state == EXECUTE && (op_bne || op_j || op_jr || op_sys))
                              || (state == MEM && op_sw && mem_ack)
                              || (state == WRITEBACK));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH: if (mem_ack) begin
          ir    <= mem_rdata;
          pc    <= pc + 32'd4;
          state <= DECODE;
        end
        DECODE: begin
          a     <= rf[rs];
          b     <= rf[rt];
          state <= legal ? EXECUTE : HALT;
        end
        EXECUTE: begin
          alu_out <= alu_res;
          if (op_bne) begin
            if (a != b) pc <= pc + br_off;
            state <= FETCH;
          end else if (op_j || op_jal) begin
            pc    <= jump_tgt;
            state <= op_jal ? WRITEBACK : FETCH;
          end else if (op_jr) begin
            pc    <= a;
            state <= FETCH;
          end else if (op_sys) begin
            state <= HALT;
          end else if (op_lw || op_sw) begin
            state <= MEM;
          end else begin
            state <= WRITEBACK;
          end
        end
        MEM: if (mem_ack) begin
          if (op_sw) begin
            state <= FETCH;
          end else begin
            mdr   <= mem_rdata;
            state <= WRITEBACK;
          end
        end
        WRITEBACK: begin
          if (waddr != 5'd0) rf[waddr] <= wdata;
          state <= FETCH;
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: memory responder with configurable wait states, ISA-level reference
// interpreter, table of single-instruction vectors, directed corner sequences and random programs.
module tb_cpu_multicycle;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] SYSCALL = 32'h0000_000C;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a_val;
    logic [31:0] b_val;
    logic [4:0]  dst;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ack, retired, halted;
  logic [31:0] mem_addr, mem_wdata, pc_out;
  logic [31:0] mem_rdata = 32'h0;
  logic        ack_r = 1'b0;
  logic        force_ack = 1'b0;

  logic [31:0] mem [1024];
  int          lat_cfg = 0;
  int          wcnt = 0;
  int          checks = 0;
  int          errors = 0;

  // run-time observations
  int          cyc, nret, stab_err;
  int          stamps[$];
  txn_t        dut_tr[$];
  logic        pv_req, pv_we;
  logic [31:0] pv_addr, pv_wdata;

  // reference model results
  logic [31:0] m_r [32];
  logic [31:0] m_pc;
  int          mcyc, mret;
  txn_t        mdl_tr[$];

  cpu_multicycle #(.RESET_PC(RST_PC), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc_out(pc_out),
    .retired(retired), .halted(halted));

  always #5 clk = ~clk;

  assign mem_ack = ack_r | force_ack;

  // Memory responder: acks after lat_cfg wait cycles; a store lands when acked.
  always @(negedge clk) begin
    if (mem_req) begin
      if (wcnt >= lat_cfg) begin
        ack_r     = 1'b1;
        mem_rdata = mem[mem_addr[11:2]];
        if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
        wcnt = 0;
      end else begin
        ack_r     = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        wcnt++;
      end
    end else begin
      ack_r = 1'b0;
      wcnt  = 0;
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = 32'h0;
  endtask

  task automatic m_wr(input logic [4:0] d, input logic [31:0] v);
    if (d != 5'd0) m_r[d] = v;
  endtask

  // Instruction-level interpreter; cycle cost per instruction class plus lat per memory access.
  task automatic model_run(input int lat);
    logic [31:0] mm [1024];
    logic [31:0] ins, npc, va, vb, sx, ea;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    bit          done;
    int          steps;
    mm = mem;
    foreach (m_r[i]) m_r[i] = 32'h0;
    m_pc = RST_PC; mcyc = 0; mret = 0; done = 0; steps = 0;
    mdl_tr.delete();
    while (!done && steps < 1000) begin
      steps++;
      ins = mm[m_pc[11:2]];
      mdl_tr.push_back('{1'b0, m_pc, 32'h0});
      mcyc += lat + 2;
      npc = m_pc + 32'd4;
      op = ins[31:26]; fn = ins[5:0];
      rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      sx = {{16{ins[15]}}, ins[15:0]};
      va = m_r[rs]; vb = m_r[rt];
      ea = va + sx;
      case (op)
        6'h00: case (fn)
          6'h20: begin m_wr(rd, va + vb); mcyc += 2; mret++; end
          6'h22: begin m_wr(rd, va - vb); mcyc += 2; mret++; end
          6'h2A: begin m_wr(rd, ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0); mcyc += 2; mret++; end
          6'h08: begin npc = va; mcyc += 1; mret++; end
          6'h0C: begin mcyc += 1; mret++; done = 1; end
          default: done = 1;
        endcase
        6'h08: begin m_wr(rt, ea); mcyc += 2; mret++; end
        6'h0E: begin m_wr(rt, va ^ {16'h0, ins[15:0]}); mcyc += 2; mret++; end
        6'h23: begin
          mdl_tr.push_back('{1'b0, ea, 32'h0});
          m_wr(rt, mm[ea[11:2]]);
          mcyc += 3 + lat; mret++;
        end
        6'h2B: begin
          mdl_tr.push_back('{1'b1, ea, vb});
          mm[ea[11:2]] = vb;
          mcyc += 2 + lat; mret++;
        end
        6'h05: begin
          if (va != vb) npc = npc + (sx << 2);
          mcyc += 1; mret++;
        end
        6'h02: begin npc = {npc[31:28], ins[25:0], 2'b00}; mcyc += 1; mret++; end
        6'h03: begin m_wr(5'd31, npc); npc = {npc[31:28], ins[25:0], 2'b00}; mcyc += 2; mret++; end
        default: done = 1;
      endcase
      m_pc = npc;
    end
  endtask

  // Reset, release, then observe every cycle until halted or budget expires.
  task automatic run(input int lat, input int budget);
    bit timed_out;
    lat_cfg = lat;
    dut_tr.delete(); stamps.delete();
    nret = 0; cyc = 0; stab_err = 0; timed_out = 0; pv_req = 0;
    pv_we = 0; pv_addr = 0; pv_wdata = 0;
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (halted) break;
      if (cyc >= budget) begin timed_out = 1; break; end
      if (retired) begin nret++; stamps.push_back(cyc); end
      if (pv_req && (!mem_req || mem_addr != pv_addr || mem_we != pv_we ||
                     (mem_we && mem_wdata != pv_wdata))) stab_err++;
      if (mem_req && mem_ack) dut_tr.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : 32'h0});
      pv_req = mem_req && !mem_ack;
      pv_we = mem_we; pv_addr = mem_addr; pv_wdata = mem_wdata;
      cyc++;
    end
    chk("timeout", 32'(timed_out), 32'd0);
  endtask

  task automatic compare(input string tag);
    int bad;
    chk({tag, ".halted"}, 32'(halted), 32'd1);
    chk({tag, ".pc"}, pc_out, m_pc);
    chk({tag, ".retired"}, nret, mret);
    chk({tag, ".cycles"}, cyc, mcyc);
    chk({tag, ".stable"}, stab_err, 0);
    bad = -1;
    for (int i = 0; i < 32; i++) if (dut.rf[i] !== m_r[i] && bad < 0) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s.regs r%0d got %h expected %h", tag, bad, dut.rf[bad], m_r[bad]);
    end
    chk({tag, ".trace_len"}, dut_tr.size(), mdl_tr.size());
    bad = -1;
    for (int i = 0; i < dut_tr.size() && i < mdl_tr.size(); i++)
      if (dut_tr[i] !== mdl_tr[i] && bad < 0) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s.trace #%0d got we=%b addr=%h wd=%h expected we=%b addr=%h wd=%h", tag, bad,
               dut_tr[bad].we, dut_tr[bad].addr, dut_tr[bad].wdata,
               mdl_tr[bad].we, mdl_tr[bad].addr, mdl_tr[bad].wdata);
    end
  endtask

  task automatic gen_random(input int n);
    logic [5:0] fsel [3];
    fsel[0] = 6'h20; fsel[1] = 6'h22; fsel[2] = 6'h2A;
    clear_mem();
    for (int i = 0; i < n; i++) begin
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm, off;
      int          k;
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      off = 16'h0800 + 16'(4 * $urandom_range(0, 15));
      k   = $urandom_range(0, 7);
      case (k)
        0, 6:    mem[i] = enc_r(rs, rt, rd, fsel[$urandom_range(0, 2)]);
        1:       mem[i] = enc_i(6'h08, rs, rt, imm);
        2:       mem[i] = enc_i(6'h0E, rs, rt, imm);
        3:       mem[i] = enc_i(6'h2B, 5'd0, rt, off);
        4:       mem[i] = enc_i(6'h23, 5'd0, rt, off);
        5:       mem[i] = enc_i(6'h05, rs, rt, 16'($urandom_range(0, 2)));
        default: mem[i] = enc_j(6'h02, 26'(i + 2));
      endcase
    end
    for (int i = n; i < n + 4; i++) mem[i] = SYSCALL;
    for (int i = 512; i < 528; i++) mem[i] = $urandom;
  endtask

  initial begin
    vec_t        vecs [8];
    logic [31:0] exp_f [6];
    bit          found;

    vecs[0] = '{"add",       enc_r(5'd1, 5'd2, 5'd3, 6'h20),    32'd7,         32'd8, 5'd3, 32'd15};
    vecs[1] = '{"add_wrap",  enc_r(5'd1, 5'd2, 5'd3, 6'h20),    32'hFFFF_FFFF, 32'd2, 5'd3, 32'd1};
    vecs[2] = '{"sub_neg",   enc_r(5'd1, 5'd2, 5'd3, 6'h22),    32'd5,         32'd7, 5'd3, 32'hFFFF_FFFE};
    vecs[3] = '{"slt_true",  enc_r(5'd1, 5'd2, 5'd3, 6'h2A),    32'hFFFF_FFFF, 32'd1, 5'd3, 32'd1};
    vecs[4] = '{"slt_false", enc_r(5'd1, 5'd2, 5'd3, 6'h2A),    32'd1, 32'hFFFF_FFFF, 5'd3, 32'd0};
    vecs[5] = '{"addi_neg",  enc_i(6'h08, 5'd1, 5'd3, 16'hFFFF), 32'd10,        32'd0, 5'd3, 32'd9};
    vecs[6] = '{"xori_zext", enc_i(6'h0E, 5'd1, 5'd3, 16'h8000), 32'hFFFF_0000, 32'd0, 5'd3, 32'hFFFF_8000};
    vecs[7] = '{"addi_wrap", enc_i(6'h08, 5'd1, 5'd3, 16'h0001), 32'h7FFF_FFFF, 32'd0, 5'd3, 32'h8000_0000};

    // Reset state, with a stray ack that must be ignored.
    reset = 1'b1; force_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    chk("rst.retired", 32'(retired), 32'd0);
    chk("rst.pc", pc_out, RST_PC);
    force_ack = 1'b0;

    // Single-instruction vectors: operands loaded from 0x200/0x204 into $1/$2.
    foreach (vecs[v]) begin
      clear_mem();
      mem[0] = enc_i(6'h23, 5'd0, 5'd1, 16'h0200);
      mem[1] = enc_i(6'h23, 5'd0, 5'd2, 16'h0204);
      mem[2] = vecs[v].instr;
      mem[3] = SYSCALL;
      mem[128] = vecs[v].a_val;
      mem[129] = vecs[v].b_val;
      model_run(0);
      run(0, 300);
      chk({vecs[v].name, ".dst"}, dut.rf[vecs[v].dst], vecs[v].exp);
      chk({vecs[v].name, ".ncyc"}, (stamps.size() >= 3) ? stamps[2] - stamps[1] : -1, 4);
      compare(vecs[v].name);
    end

    // Arithmetic program ending in SYSCALL.
    clear_mem();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    mem[3] = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);
    mem[4] = SYSCALL;
    model_run(0);
    run(0, 300);
    chk("prog.r3", dut.rf[3], 32'd2);
    chk("prog.r4", dut.rf[4], 32'd1);
    chk("prog.retired", nret, 5);
    chk("prog.cycles", cyc, 19);
    compare("prog");

    // Store then load with three wait cycles per access.
    clear_mem();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0010);
    mem[2] = enc_i(6'h23, 5'd0, 5'd5, 16'h0010);
    mem[3] = SYSCALL;
    model_run(3);
    run(3, 400);
    chk("swlw.r5", dut.rf[5], 32'd5);
    if (dut_tr.size() >= 6) begin
      chk("sw.we", 32'(dut_tr[2].we), 32'd1);
      chk("sw.addr", dut_tr[2].addr, 32'h10);
      chk("sw.wdata", dut_tr[2].wdata, 32'd5);
      chk("lw.we", 32'(dut_tr[4].we), 32'd0);
      chk("lw.addr", dut_tr[4].addr, 32'h10);
    end else chk("swlw.trace_len", dut_tr.size(), 6);
    compare("swlw");

    // BNE taken back to 0x4 once, then falls through to 0xC.
    clear_mem();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd2);
    mem[1] = enc_i(6'h08, 5'd1, 5'd1, 16'hFFFF);
    mem[2] = enc_i(6'h05, 5'd1, 5'd0, 16'hFFFE);
    mem[3] = SYSCALL;
    exp_f = '{32'h0, 32'h4, 32'h8, 32'h4, 32'h8, 32'hC};
    model_run(0);
    run(0, 300);
    chk("bne.nfetch", dut_tr.size(), 6);
    for (int i = 0; i < 6 && i < dut_tr.size(); i++) chk($sformatf("bne.fetch%0d", i), dut_tr[i].addr, exp_f[i]);
    chk("bne.ncyc", (stamps.size() >= 3) ? stamps[2] - stamps[1] : -1, 3);
    compare("bne");

    // J to 0x20, JAL 0x100 -> 0x400, JR $31 back to 0x24.
    clear_mem();
    mem[0]   = enc_j(6'h02, 26'h8);
    mem[8]   = enc_j(6'h03, 26'h100);
    mem[256] = enc_r(5'd31, 5'd0, 5'd0, 6'h08);
    mem[9]   = SYSCALL;
    model_run(0);
    run(0, 300);
    chk("jal.r31", dut.rf[31], 32'h24);
    if (dut_tr.size() >= 4) begin
      chk("jal.f1", dut_tr[1].addr, 32'h20);
      chk("jal.f2", dut_tr[2].addr, 32'h400);
      chk("jal.f3", dut_tr[3].addr, 32'h24);
    end else chk("jal.nfetch", dut_tr.size(), 4);
    if (stamps.size() >= 3) begin
      chk("j.ncyc", stamps[0] + 1, 3);
      chk("jal.ncyc", stamps[1] - stamps[0], 4);
      chk("jr.ncyc", stamps[2] - stamps[1], 3);
    end else chk("jal.nret", stamps.size(), 3);
    compare("jal");

    // Reset while LW waits in MEM, with an ack landing in the reset cycle.
    clear_mem();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
    mem[1] = enc_i(6'h23, 5'd0, 5'd5, 16'h0010);
    mem[2] = SYSCALL;
    mem[4] = 32'h0000_1234;
    lat_cfg = 3;
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk); #1;
      if (mem_req && mem_addr == 32'h10) found = 1;
    end
    chk("rstmem.reached", 32'(found), 32'd1);
    @(posedge clk); #1 reset = 1'b1; force_ack = 1'b1; mem_rdata = 32'h0000_1234;
    @(negedge clk); #1;
    chk("rstmem.req", 32'(mem_req), 32'd0);
    @(posedge clk); #1 reset = 1'b0; force_ack = 1'b0;
    @(negedge clk); #1;
    chk("rstmem.fetch_req", 32'(mem_req), 32'd1);
    chk("rstmem.fetch_we", 32'(mem_we), 32'd0);
    chk("rstmem.fetch_addr", mem_addr, RST_PC);
    chk("rstmem.r5", dut.rf[5], 32'd0);
    found = 0;
    for (int i = 0; i < 32; i++) if (dut.rf[i] !== 32'h0) found = 1;
    chk("rstmem.regs_zero", 32'(found), 32'd0);

    // Write to $0 then an illegal opcode.
    clear_mem();
    mem[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    mem[1] = 32'hFC00_0000;
    model_run(0);
    run(0, 300);
    chk("ill.r0", dut.rf[0], 32'd0);
    chk("ill.retired", nret, 1);
    chk("ill.cycles", cyc, 6);
    compare("ill");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk($sformatf("ill.hold_req%0d", i), 32'({mem_req, retired, halted}), 32'b001);
      chk($sformatf("ill.hold_pc%0d", i), pc_out, 32'h8);
    end

    // Random programs at random latency against the interpreter.
    for (int it = 0; it < 12; it++) begin
      int lat;
      lat = $urandom_range(0, 2);
      gen_random(16);
      model_run(lat);
      run(lat, 2000);
      compare($sformatf("rnd%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
